// File: rtl/i2s_pkg.sv
// Shared constants, startup state encoding and the slot-to-bit mapping
// used by the I2S transmit frame generator.
package i2s_pkg;

    localparam int unsigned CNT_W         = 8;
    localparam int unsigned SLOT_BITS     = 32;
    localparam int unsigned BICK_DIV_LOG2 = 2;
    localparam int unsigned UNDERRUN_W    = 8;
    localparam int unsigned SAMPLE_MAX_W  = 24;
    localparam int unsigned SLOT_IDX_W    = $clog2(SLOT_BITS);

    typedef enum logic {
        ST_STARTUP,
        ST_RUN
    } startup_state_t;

    // Slot 0 is the one-BICK I2S delay; slots 1..w carry the word MSB first.
    function automatic logic slot_bit(
        input logic [SAMPLE_MAX_W-1:0] sample,
        input logic [SLOT_IDX_W-1:0]   slot,
        input int unsigned             w
    );
        logic [SLOT_IDX_W-1:0] idx;
        logic                  b;
        b   = 1'b0;
        idx = SLOT_IDX_W'(w - 32'(slot));
        if (slot != '0 && 32'(slot) <= w) begin
            b = sample[idx];
        end
        return b;
    endfunction

endpackage

// File: rtl/i2s_tx_serializer.sv
// Shadow sample pair, frame-end latch with underrun counting, and the
// serial data shifter aligned to the falling edge of BICK.
module i2s_tx_serializer
    import i2s_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic                  clk_256fs,
    input  logic                  rst_n,
    input  logic [CNT_W-1:0]      cnt,
    input  logic                  ready,
    input  logic                  mute_q,
    input  logic [W-1:0]          sample_l,
    input  logic [W-1:0]          sample_r,
    input  logic                  sample_valid,
    output logic                  sdout,
    output logic [UNDERRUN_W-1:0] underrun_cnt
);

    localparam int unsigned HI_W = CNT_W - BICK_DIV_LOG2;

    logic [W-1:0]            shadow_l;
    logic [W-1:0]            shadow_r;
    logic                    latch;
    logic                    bit_step;
    logic [HI_W-1:0]         slot_next;
    logic [SAMPLE_MAX_W-1:0] word;
    logic                    sd_next;

    assign latch    = (cnt == '1);
    assign bit_step = (cnt[BICK_DIV_LOG2-1:0] == '1);

    // Only used on bit_step edges, where the low count bits roll over and
    // the channel/slot field simply advances by one.
    assign slot_next = cnt[CNT_W-1:BICK_DIV_LOG2] + 1'b1;

    always_comb begin
        word        = '0;
        word[W-1:0] = slot_next[HI_W-1] ? shadow_r : shadow_l;
        sd_next     = 1'b0;
        if (ready && !mute_q) begin
            sd_next = slot_bit(word, slot_next[SLOT_IDX_W-1:0], W);
        end
    end

    always_ff @(posedge clk_256fs or negedge rst_n) begin
        if (!rst_n) begin
            shadow_l     <= '0;
            shadow_r     <= '0;
            underrun_cnt <= '0;
        end else if (latch) begin
            if (sample_valid) begin
                shadow_l <= sample_l;
                shadow_r <= sample_r;
            end else if (ready && underrun_cnt != '1) begin
                underrun_cnt <= underrun_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_256fs or negedge rst_n) begin
        if (!rst_n) begin
            sdout <= 1'b0;
        end else if (bit_step) begin
            sdout <= sd_next;
        end
    end

endmodule

// File: rtl/i2s_tx_fs_gen.sv
// I2S master transmitter: derives BICK/LRCK from the 256fs clock, sequences
// the startup mute and frame-aligned mute, and drives the serializer.
module i2s_tx_fs_gen
    import i2s_pkg::*;
#(
    parameter int unsigned W           = 16,
    parameter int unsigned MUTE_FRAMES = 16
) (
    input  logic                  clk_256fs,
    input  logic                  rst_n,
    input  logic [W-1:0]          sample_l,
    input  logic [W-1:0]          sample_r,
    input  logic                  sample_valid,
    input  logic                  mute,
    output logic                  fs_strobe,
    output logic                  bick,
    output logic                  lrck,
    output logic                  sdout,
    output logic                  ready,
    output logic [UNDERRUN_W-1:0] underrun_cnt
);

    if (W < 8 || W > SAMPLE_MAX_W) begin : g_bad_w
        $error("i2s_tx_fs_gen: W must be in 8..24");
    end
    if (MUTE_FRAMES < 1) begin : g_bad_mute
        $error("i2s_tx_fs_gen: MUTE_FRAMES must be at least 1");
    end

    localparam int unsigned      FC_W     = $clog2(MUTE_FRAMES + 1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(MUTE_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = '1;
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_LAST - 1'b1;

    logic [CNT_W-1:0] cnt;
    logic             frame_end;
    logic             mute_q;
    logic [FC_W-1:0]  frame_cnt;
    logic [FC_W-1:0]  frame_cnt_d;
    startup_state_t   state_q;
    startup_state_t   state_d;

    assign frame_end = (cnt == CNT_LAST);

    always_ff @(posedge clk_256fs or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            fs_strobe <= 1'b0;
        end else begin
            cnt       <= cnt + 1'b1;
            fs_strobe <= (cnt == CNT_PRE);
        end
    end

    // Clocks are taken straight from counter flops so they cannot glitch.
    assign bick = cnt[BICK_DIV_LOG2-1];
    assign lrck = cnt[CNT_W-1];

    always_ff @(posedge clk_256fs or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_STARTUP;
            frame_cnt <= '0;
        end else begin
            state_q   <= state_d;
            frame_cnt <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt;
        if (state_q == ST_STARTUP && frame_end) begin
            frame_cnt_d = frame_cnt + 1'b1;
            if (frame_cnt == FC_LAST) begin
                state_d = ST_RUN;
            end
        end
    end

    assign ready = (state_q == ST_RUN);

    always_ff @(posedge clk_256fs or negedge rst_n) begin
        if (!rst_n) begin
            mute_q <= 1'b1;
        end else if (frame_end) begin
            mute_q <= mute;
        end
    end

    i2s_tx_serializer #(
        .W (W)
    ) u_serializer (
        .clk_256fs    (clk_256fs),
        .rst_n        (rst_n),
        .cnt          (cnt),
        .ready        (ready),
        .mute_q       (mute_q),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sdout        (sdout),
        .underrun_cnt (underrun_cnt)
    );

endmodule

// File: tb/tb_i2s_tx_fs_gen.sv
// Scoreboard bench for i2s_tx_fs_gen: stimulus pushes the expected frame
// content per frame, a monitor captures sdout per frame and compares.
module tb_i2s_tx_fs_gen;

    localparam int unsigned W  = 16;
    localparam int unsigned MF = 2;

    logic          clk_256fs = 1'b0;
    logic          clk_run   = 1'b0;
    logic          rst_n     = 1'b1;
    logic [W-1:0]  sample_l  = '0;
    logic [W-1:0]  sample_r  = '0;
    logic          sample_valid = 1'b0;
    logic          mute      = 1'b0;
    logic          fs_strobe;
    logic          bick;
    logic          lrck;
    logic          sdout;
    logic          ready;
    logic [7:0]    underrun_cnt;

    i2s_tx_fs_gen #(
        .W           (W),
        .MUTE_FRAMES (MF)
    ) dut (
        .clk_256fs    (clk_256fs),
        .rst_n        (rst_n),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .mute         (mute),
        .fs_strobe    (fs_strobe),
        .bick         (bick),
        .lrck         (lrck),
        .sdout        (sdout),
        .ready        (ready),
        .underrun_cnt (underrun_cnt)
    );

    always begin
        #5;
        if (clk_run) clk_256fs = ~clk_256fs;
    end

    typedef struct {
        logic [63:0] bits;
        logic [7:0]  und;
        logic        rdy;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference frame position: counts 256fs cycles since reset release.
    logic [7:0] mcnt;
    always @(posedge clk_256fs or negedge rst_n) begin
        if (!rst_n) mcnt <= 8'd0;
        else        mcnt <= mcnt + 8'd1;
    end

    logic prev_sd = 1'b0;
    always @(negedge clk_256fs) begin
        if (rst_n) begin
            check("bick", 64'(bick), 64'(mcnt[1]));
            check("lrck", 64'(lrck), 64'(mcnt[7]));
            check("fs_strobe", 64'(fs_strobe), 64'(mcnt == 8'd255));
            if (mcnt[1:0] == 2'd3) check("sdout_stable_bick_high", 64'(sdout), 64'(prev_sd));
            prev_sd = sdout;
        end
    end

    logic [63:0] cap = '0;
    always @(negedge clk_256fs) begin
        if (!rst_n) begin
            cap = '0;
        end else begin
            if (mcnt[1:0] == 2'd2) cap[~mcnt[7:2]] = sdout;
            if (fs_strobe) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL frame_queue: frame ended with no expectation queued (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_bits", cap, e.bits);
                    check("underrun_cnt", 64'(underrun_cnt), 64'(e.und));
                    check("ready", 64'(ready), 64'(e.rdy));
                end
                cap = '0;
            end
        end
    end

    logic [W-1:0] sh_l, sh_r;
    logic [7:0]   m_und;
    int           m_frames;
    logic         m_ready, m_mute;

    task automatic push_exp();
        exp_t x;
        x.bits = (m_ready && !m_mute) ? {1'b0, sh_l, 15'b0, 1'b0, sh_r, 15'b0} : 64'd0;
        x.und  = m_und;
        x.rdy  = m_ready;
        exp_q.push_back(x);
    endtask

    task automatic do_reset(input logic clock_running);
        rst_n = 1'b0;
        #1;
        check("rst_sdout", 64'(sdout), 64'd0);
        check("rst_bick", 64'(bick), 64'd0);
        check("rst_lrck", 64'(lrck), 64'd0);
        check("rst_fs_strobe", 64'(fs_strobe), 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_underrun_cnt", 64'(underrun_cnt), 64'd0);
        sh_l = '0; sh_r = '0; m_und = '0; m_frames = 0; m_ready = 1'b0; m_mute = 1'b1;
        exp_q.delete();
        if (clock_running) repeat (10) @(negedge clk_256fs);
        else #100;
        clk_run = 1'b1;
        @(negedge clk_256fs);
        #2;
        rst_n = 1'b1;
        push_exp();
    endtask

    task automatic wait_boundary();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk_256fs);
            if (fs_strobe) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL boundary_timeout: no fs_strobe in 300 cycles, expected one");
        end
        @(posedge clk_256fs);
        #1;
    endtask

    // Drives one frame's inputs, waits for its latch edge, then updates the
    // model and queues the expected content of the following frame.
    task automatic run_frame(input logic [W-1:0] l, input logic [W-1:0] r,
                             input logic v, input logic m, input logic mute_mid);
        sample_l     = l;
        sample_r     = r;
        sample_valid = v;
        if (mute_mid) repeat (100) @(negedge clk_256fs);
        mute = m;
        wait_boundary();
        if (v) begin
            sh_l = l;
            sh_r = r;
        end else if (m_ready && m_und != 8'd255) begin
            m_und = m_und + 8'd1;
        end
        m_mute = m;
        if (!m_ready) begin
            if (m_frames == int'(MF) - 1) m_ready = 1'b1;
            m_frames++;
        end
        push_exp();
    endtask

    initial begin
        #2;
        do_reset(1'b0);
        run_frame(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        run_frame(16'h8001, 16'h7FFE, 1'b1, 1'b0, 1'b0);
        run_frame(16'hA5C3, 16'h3C5A, 1'b1, 1'b0, 1'b0);
        run_frame(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
        run_frame(16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 1'b0);
        run_frame(16'h1234, 16'h5678, 1'b1, 1'b1, 1'b1);
        run_frame(16'h4321, 16'h8765, 1'b1, 1'b0, 1'b1);
        run_frame(16'hCAFE, 16'hBEEF, 1'b0, 1'b1, 1'b0);
        run_frame(16'hABCD, 16'h0123, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 260; i++) run_frame(16'h5555, 16'hAAAA, 1'b0, 1'b0, 1'b0);
        run_frame(16'hFFFF, 16'h8000, 1'b1, 1'b0, 1'b0);
        sample_l = 16'h9999;
        sample_valid = 1'b1;
        repeat (130) @(negedge clk_256fs);
        check("pre_rst_ready", 64'(ready), 64'd1);
        check("pre_rst_underrun_cnt", 64'(underrun_cnt), 64'd255);
        #2;
        do_reset(1'b1);
        run_frame(16'hDEAD, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        run_frame(16'h1357, 16'h2468, 1'b1, 1'b0, 1'b0);
        run_frame(16'h0001, 16'h8000, 1'b1, 1'b0, 1'b0);
        run_frame(16'h0002, 16'h0003, 1'b1, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_500_000;
        n_errors++;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
